// File: rtl/count_pkg.sv
// Shared types and transaction field widths for the parametrised counter family.
package count_pkg;

  typedef enum logic {CNT_DOWN, CNT_UP} dir_e;
  typedef enum logic {MODE_WRAP, MODE_SAT} mode_e;

  localparam int unsigned TXN_WIDTH  = 8;
  localparam int unsigned TXN_STEP_W = 4;

endpackage

// File: rtl/count_step_calc.sv
// Combinational next-value calculation for one enabled step, with range-exit events.
module count_step_calc
  import count_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned MOD   = 2 ** WIDTH
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] s_eff,
  input  dir_e             dir,
  input  mode_e            mode,
  output logic [WIDTH-1:0] nxt,
  output logic             ovf_evt,
  output logic             udf_evt
);

  localparam logic [WIDTH:0] MOD_V  = (WIDTH + 1)'(MOD);
  localparam logic [WIDTH:0] MOD_M1 = (WIDTH + 1)'(MOD - 1);

  logic [WIDTH:0] sum;

  always_comb begin
    sum     = {1'b0, count} + {1'b0, s_eff};
    nxt     = count;
    ovf_evt = 1'b0;
    udf_evt = 1'b0;
    if (dir == CNT_UP) begin
      if (sum <= MOD_M1) begin
        nxt = sum[WIDTH-1:0];
      end else begin
        ovf_evt = 1'b1;
        nxt     = (mode == MODE_SAT) ? WIDTH'(MOD_M1) : WIDTH'(sum - MOD_V);
      end
    end else begin
      if (s_eff <= count) begin
        nxt = count - s_eff;
      end else begin
        udf_evt = 1'b1;
        nxt     = (mode == MODE_SAT) ? '0
                                     : WIDTH'({1'b0, count} + MOD_V - {1'b0, s_eff});
      end
    end
  end

endmodule

// File: rtl/param_counter.sv
// Up/down counter with configurable width, modulus and step; wrap or saturate,
// terminal-count pulse and sticky overflow/underflow flags.
module param_counter
  import count_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned MOD    = 2 ** WIDTH,
  parameter int unsigned STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [WIDTH-1:0]  d_in,
  input  logic              up_dn,
  input  logic [STEP_W-1:0] step,
  input  logic              sat_mode,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              ovf,
  output logic              udf
);

  if (MOD < 2 || MOD > (2 ** WIDTH)) begin : g_bad_mod
    $error("param_counter: MOD must lie in 2..2**WIDTH");
  end

  // Comparison width wide enough for both the raw step and MOD-1.
  localparam int unsigned CW = (STEP_W > WIDTH + 1) ? STEP_W : WIDTH + 1;

  logic [WIDTH-1:0] s_eff;
  logic [WIDTH-1:0] d_clamp;
  logic [WIDTH-1:0] nxt;
  logic             ovf_evt;
  logic             udf_evt;
  logic             stepping;
  dir_e             dir;
  mode_e            mode;

  always_comb begin
    s_eff    = (CW'(step) > CW'(MOD - 1)) ? WIDTH'(MOD - 1) : WIDTH'(step);
    d_clamp  = ({1'b0, d_in} > (WIDTH + 1)'(MOD - 1)) ? WIDTH'(MOD - 1) : d_in;
    dir      = up_dn ? CNT_UP : CNT_DOWN;
    mode     = sat_mode ? MODE_SAT : MODE_WRAP;
    stepping = en & ~load;
  end

  count_step_calc #(
    .WIDTH (WIDTH),
    .MOD   (MOD)
  ) u_step (
    .count   (count),
    .s_eff   (s_eff),
    .dir     (dir),
    .mode    (mode),
    .nxt     (nxt),
    .ovf_evt (ovf_evt),
    .udf_evt (udf_evt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      if (load) begin
        count <= d_clamp;
      end else if (en) begin
        count <= nxt;
      end
      tc  <= stepping & (ovf_evt | udf_evt);
      // A same-edge event outranks clr_flags.
      ovf <= (ovf & ~clr_flags) | (stepping & ovf_evt);
      udf <= (udf & ~clr_flags) | (stepping & udf_evt);
    end
  end

endmodule

// File: tb/tb_param_counter.sv
// Bench for param_counter: two instances (MOD=200 and MOD=8) against an integer reference model.
module tb_param_counter;
  import count_pkg::*;

  localparam int unsigned W  = TXN_WIDTH;
  localparam int unsigned SW = TXN_STEP_W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0, load = 1'b0, up_dn = 1'b1, sat_mode = 1'b0, clr_flags = 1'b0;
  logic [W-1:0]  d_in = '0;
  logic [SW-1:0] step = '0;

  logic [W-1:0]  cnt_o [2];
  logic          tc_o  [2];
  logic          ovf_o [2];
  logic          udf_o [2];

  int checks = 0;
  int errors = 0;

  int mods  [2] = '{200, 8};
  int m_cnt [2];
  bit m_tc  [2];
  bit m_ovf [2];
  bit m_udf [2];

  always #5 clk = ~clk;

  param_counter #(.WIDTH(W), .MOD(200), .STEP_W(SW)) dut_a (
    .clk(clk), .rst(rst), .en(en), .load(load), .d_in(d_in), .up_dn(up_dn),
    .step(step), .sat_mode(sat_mode), .clr_flags(clr_flags),
    .count(cnt_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0]), .udf(udf_o[0])
  );

  param_counter #(.WIDTH(W), .MOD(8), .STEP_W(SW)) dut_b (
    .clk(clk), .rst(rst), .en(en), .load(load), .d_in(d_in), .up_dn(up_dn),
    .step(step), .sat_mode(sat_mode), .clr_flags(clr_flags),
    .count(cnt_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1]), .udf(udf_o[1])
  );

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_tc[i] = 0; m_ovf[i] = 0; m_udf[i] = 0;
    end
  endfunction

  // Integer reference: compute the unclipped result, then fold or clip it.
  function automatic void model_edge(int i);
    int s, r, top;
    bit eo, eu;
    top = mods[i] - 1;
    s   = (int'(step) > top) ? top : int'(step);
    eo  = 0;
    eu  = 0;
    if (load) begin
      m_cnt[i] = (int'(d_in) > top) ? top : int'(d_in);
    end else if (en) begin
      r = up_dn ? m_cnt[i] + s : m_cnt[i] - s;
      if (r > top) begin
        eo = 1;
        r  = sat_mode ? top : r - mods[i];
      end else if (r < 0) begin
        eu = 1;
        r  = sat_mode ? 0 : r + mods[i];
      end
      m_cnt[i] = r;
    end
    m_tc[i]  = eo | eu;
    m_ovf[i] = eo | (m_ovf[i] & !clr_flags);
    m_udf[i] = eu | (m_udf[i] & !clr_flags);
  endfunction

  task automatic cyc();
    @(posedge clk);
    if (rst) begin
      model_edge(0);
      model_edge(1);
    end
    #1;
  endtask

  task automatic set_in(bit l, bit e, bit u, int s, bit sat, bit clr, int d);
    load = l; en = e; up_dn = u; step = SW'(s); sat_mode = sat; clr_flags = clr; d_in = W'(d);
  endtask

  task automatic test_reset();
    checks++;
    if (cnt_o[0] !== 8'd0 || tc_o[0] !== 1'b0 || ovf_o[0] !== 1'b0 || udf_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial: count=%0d tc=%b ovf=%b udf=%b, required 0 0 0 0",
               cnt_o[0], tc_o[0], ovf_o[0], udf_o[0]);
    end
    @(negedge clk);
    rst = 1'b1;
    set_in(0, 1, 1, 3, 0, 0, 0);
    repeat (19) cyc();
    checks++;
    if (cnt_o[0] !== 8'd57) begin
      errors++;
      $display("FAIL reset_count_to_57: count=%0d, required 57", cnt_o[0]);
    end
    #3 rst = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (cnt_o[i] !== 8'd0 || tc_o[i] !== 1'b0 || ovf_o[i] !== 1'b0 || udf_o[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_async[%0d]: count=%0d tc=%b ovf=%b udf=%b, required 0 0 0 0",
                 i, cnt_o[i], tc_o[i], ovf_o[i], udf_o[i]);
      end
    end
    set_in(0, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_wrap_up();
    set_in(1, 0, 1, 0, 0, 0, 198);
    cyc();
    set_in(0, 1, 1, 3, 0, 0, 0);
    cyc();
    checks++;
    if (cnt_o[0] !== 8'd1 || tc_o[0] !== 1'b1 || ovf_o[0] !== 1'b1 || udf_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL wrap_up: count=%0d tc=%b ovf=%b udf=%b, required 1 1 1 0",
               cnt_o[0], tc_o[0], ovf_o[0], udf_o[0]);
    end
    set_in(0, 0, 1, 3, 0, 0, 0);
    cyc();
    checks++;
    if (tc_o[0] !== 1'b0 || cnt_o[0] !== 8'd1) begin
      errors++;
      $display("FAIL wrap_tc_single: count=%0d tc=%b, required 1 0", cnt_o[0], tc_o[0]);
    end
  endtask

  task automatic test_sat_down();
    set_in(1, 0, 0, 0, 1, 0, 2);
    cyc();
    set_in(0, 1, 0, 5, 1, 0, 0);
    cyc();
    checks++;
    if (cnt_o[0] !== 8'd0 || tc_o[0] !== 1'b1 || udf_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL sat_down: count=%0d tc=%b udf=%b, required 0 1 1", cnt_o[0], tc_o[0], udf_o[0]);
    end
    cyc();
    checks++;
    if (cnt_o[0] !== 8'd0 || tc_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL sat_down_repeat: count=%0d tc=%b, required 0 1", cnt_o[0], tc_o[0]);
    end
  endtask

  task automatic test_load_clamp();
    set_in(1, 1, 1, 7, 0, 0, 250);
    cyc();
    checks++;
    if (cnt_o[0] !== 8'd199 || tc_o[0] !== 1'b0 || ovf_o[0] !== 1'b1 || udf_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL load_clamp: count=%0d tc=%b ovf=%b udf=%b, required 199 0 1 1",
               cnt_o[0], tc_o[0], ovf_o[0], udf_o[0]);
    end
    checks++;
    if (cnt_o[1] !== 8'd7) begin
      errors++;
      $display("FAIL load_clamp_mod8: count=%0d, required 7", cnt_o[1]);
    end
  endtask

  task automatic test_flag_clear();
    set_in(1, 0, 1, 0, 0, 0, 198);
    cyc();
    set_in(0, 1, 1, 3, 0, 1, 0);
    cyc();
    checks++;
    if (ovf_o[0] !== 1'b1 || udf_o[0] !== 1'b0 || cnt_o[0] !== 8'd1) begin
      errors++;
      $display("FAIL clr_race: ovf=%b udf=%b count=%0d, required 1 0 1", ovf_o[0], udf_o[0], cnt_o[0]);
    end
    set_in(0, 0, 1, 3, 0, 1, 0);
    cyc();
    checks++;
    if (ovf_o[0] !== 1'b0 || udf_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL clr_plain: ovf=%b udf=%b, required 0 0", ovf_o[0], udf_o[0]);
    end
  endtask

  task automatic test_hold();
    set_in(1, 0, 1, 0, 0, 0, 100);
    cyc();
    for (int i = 0; i < 10; i++) begin
      set_in(0, i >= 5, 1'($urandom), (i >= 5) ? 0 : int'($urandom_range(15)),
             1'($urandom), 0, 0);
      cyc();
      checks++;
      if (cnt_o[0] !== 8'd100 || tc_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: count=%0d tc=%b, required 100 0", i, cnt_o[0], tc_o[0]);
      end
    end
    set_in(1, 0, 1, 0, 0, 0, 5);
    cyc();
    set_in(0, 1, 1, 15, 0, 0, 0);
    cyc();
    checks++;
    if (cnt_o[1] !== 8'd4 || tc_o[1] !== 1'b1) begin
      errors++;
      $display("FAIL step_clamp_mod8: count=%0d tc=%b, required 4 1", cnt_o[1], tc_o[1]);
    end
    checks++;
    if (cnt_o[0] !== 8'd20 || tc_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL step15_mod200: count=%0d tc=%b, required 20 0", cnt_o[0], tc_o[0]);
    end
  endtask

  task automatic test_back_to_back();
    set_in(1, 0, 1, 0, 1, 1, 250);
    cyc();
    set_in(0, 1, 1, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if (cnt_o[0] !== 8'd199 || tc_o[0] !== 1'b1 || ovf_o[0] !== 1'b1) begin
        errors++;
        $display("FAIL back_to_back[%0d]: count=%0d tc=%b ovf=%b, required 199 1 1",
                 i, cnt_o[0], tc_o[0], ovf_o[0]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      set_in($urandom_range(7) == 0, $urandom_range(3) != 0, 1'($urandom),
             int'($urandom_range(15)), 1'($urandom), $urandom_range(9) == 0,
             int'($urandom_range(255)));
      cyc();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (int'(cnt_o[i]) != m_cnt[i] || tc_o[i] !== m_tc[i] ||
            ovf_o[i] !== m_ovf[i] || udf_o[i] !== m_udf[i]) begin
          errors++;
          $display("FAIL random[%0d] inst%0d: count=%0d tc=%b ovf=%b udf=%b, required %0d %b %b %b",
                   n, i, cnt_o[i], tc_o[i], ovf_o[i], udf_o[i],
                   m_cnt[i], m_tc[i], m_ovf[i], m_udf[i]);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    #12;
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_load_clamp();
    test_flag_clear();
    test_hold();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
